// File: rtl/memwb_stage.sv
// MEM/WB stage: load-data extraction, write-back select, 2-entry skid buffer, x0 suppression.
// Latency: 1 cycle from accept to valid_out when the write-back side is not stalled.
// Backpressure: ready_out is a flop (low only while the skid entry is full); no path from ready_in.
module memwb_stage #(
  parameter int WIDTH = 32,
  parameter int INDEX = 5,
  parameter int OFFW  = $clog2(WIDTH / 8)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             mem_to_reg_in,
  input  logic             reg_write_in,
  input  logic [INDEX-1:0] rd_in,
  input  logic [2:0]       funct3_in,
  input  logic [OFFW-1:0]  addr_off_in,
  input  logic [WIDTH-1:0] data_mem_in,
  input  logic [WIDTH-1:0] alu_res_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             reg_write_out,
  output logic [INDEX-1:0] rd_out,
  output logic [WIDTH-1:0] wb_data_out,
  output logic             fwd_valid_out,
  output logic [INDEX-1:0] fwd_rd_out,
  output logic [WIDTH-1:0] fwd_data_out
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Main entry (drives outputs) and skid entry (overflow while stalled).
  logic             m_vld;
  logic             m_wr;
  logic [INDEX-1:0] m_rd;
  logic [WIDTH-1:0] m_dat;
  logic             s_vld;
  logic             s_wr;
  logic [INDEX-1:0] s_rd;
  logic [WIDTH-1:0] s_dat;
  logic             rdy_q;

  logic [OFFW-1:0]  off_h;
  logic [OFFW-1:0]  off_w;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_h;
  logic [WIDTH-1:0] sh_w;
  logic [WIDTH-1:0] load_dat;
  logic [WIDTH-1:0] sel_dat;
  logic             accept;

  // Align the addressed lane to bit 0; sub-lane offset bits are masked so
  // misaligned halves/words read their naturally aligned container.
  always_comb begin
    off_h = addr_off_in & ~OFFW'(1);
    off_w = addr_off_in & ~OFFW'(3);
    sh_b  = data_mem_in >> {addr_off_in, 3'b000};
    sh_h  = data_mem_in >> {off_h, 3'b000};
    sh_w  = data_mem_in >> {off_w, 3'b000};
  end

  // Size/sign extension by funct3; codes not defined for this WIDTH pass the raw word.
  always_comb begin
    load_dat = data_mem_in;
    case (funct3_in)
      F3_LB:  load_dat = WIDTH'($signed(sh_b[7:0]));
      F3_LH:  load_dat = WIDTH'($signed(sh_h[15:0]));
      F3_LW:  begin
        if (WIDTH == 64) load_dat = WIDTH'($signed(sh_w[31:0]));
        else             load_dat = data_mem_in;
      end
      F3_LBU: load_dat = WIDTH'(sh_b[7:0]);
      F3_LHU: load_dat = WIDTH'(sh_h[15:0]);
      F3_LWU: begin
        if (WIDTH == 64) load_dat = WIDTH'(sh_w[31:0]);
        else             load_dat = data_mem_in;
      end
      F3_LD:  load_dat = data_mem_in;
      default: load_dat = data_mem_in;
    endcase
  end

  // Result is resolved before capture so both entries store final write-back data.
  always_comb begin
    sel_dat = mem_to_reg_in ? load_dat : alu_res_in;
    accept  = valid_in && rdy_q;
  end

  // Entry movement: skid drains first, then direct capture into main, else overflow to skid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_vld <= 1'b0;
      m_wr  <= 1'b0;
      m_rd  <= '0;
      m_dat <= '0;
      s_vld <= 1'b0;
      s_wr  <= 1'b0;
      s_rd  <= '0;
      s_dat <= '0;
      rdy_q <= 1'b1;
    end else if (flush_in) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      rdy_q <= 1'b1;
    end else if (s_vld && ready_in) begin
      m_vld <= 1'b1;
      m_wr  <= s_wr;
      m_rd  <= s_rd;
      m_dat <= s_dat;
      s_vld <= 1'b0;
      rdy_q <= 1'b1;
    end else if (accept && (!m_vld || ready_in)) begin
      m_vld <= 1'b1;
      m_wr  <= reg_write_in;
      m_rd  <= rd_in;
      m_dat <= sel_dat;
    end else if (accept) begin
      s_vld <= 1'b1;
      s_wr  <= reg_write_in;
      s_rd  <= rd_in;
      s_dat <= sel_dat;
      rdy_q <= 1'b0;
    end else if (ready_in) begin
      m_vld <= 1'b0;
    end
  end

  // Writes to x0 are never qualified; the forwarding tap sees exactly what the register file sees.
  always_comb begin
    ready_out     = rdy_q;
    valid_out     = m_vld;
    rd_out        = m_rd;
    wb_data_out   = m_dat;
    reg_write_out = m_vld && m_wr && (m_rd != '0);
    fwd_valid_out = reg_write_out;
    fwd_rd_out    = m_rd;
    fwd_data_out  = m_dat;
  end

endmodule

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage: 32-bit and 64-bit instances against a queue-based model.
// Directed literal checks pin the model, then randomized traffic with flush/reset.
// Every cycle after reset, outputs are compared against the model at the falling edge.
module tb_memwb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        a_rst, a_flush, a_vin, a_rdy_out, a_m2r, a_rw, a_vout, a_rdy_in;
  logic        a_rw_out, a_fv;
  logic [4:0]  a_rd, a_rd_out, a_frd;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [31:0] a_mem, a_alu, a_wb, a_fdat;

  // 64-bit instance signals
  logic        b_rst, b_flush, b_vin, b_rdy_out, b_m2r, b_rw, b_vout, b_rdy_in;
  logic        b_rw_out, b_fv;
  logic [4:0]  b_rd, b_rd_out, b_frd;
  logic [2:0]  b_f3;
  logic [2:0]  b_off;
  logic [63:0] b_mem, b_alu, b_wb, b_fdat;

  memwb_stage #(.WIDTH(32), .INDEX(5)) dut32 (
    .clk_in(clk), .rst_in(a_rst), .flush_in(a_flush), .valid_in(a_vin), .ready_out(a_rdy_out),
    .mem_to_reg_in(a_m2r), .reg_write_in(a_rw), .rd_in(a_rd), .funct3_in(a_f3),
    .addr_off_in(a_off), .data_mem_in(a_mem), .alu_res_in(a_alu), .valid_out(a_vout),
    .ready_in(a_rdy_in), .reg_write_out(a_rw_out), .rd_out(a_rd_out), .wb_data_out(a_wb),
    .fwd_valid_out(a_fv), .fwd_rd_out(a_frd), .fwd_data_out(a_fdat)
  );

  memwb_stage #(.WIDTH(64), .INDEX(5)) dut64 (
    .clk_in(clk), .rst_in(b_rst), .flush_in(b_flush), .valid_in(b_vin), .ready_out(b_rdy_out),
    .mem_to_reg_in(b_m2r), .reg_write_in(b_rw), .rd_in(b_rd), .funct3_in(b_f3),
    .addr_off_in(b_off), .data_mem_in(b_mem), .alu_res_in(b_alu), .valid_out(b_vout),
    .ready_in(b_rdy_in), .reg_write_out(b_rw_out), .rd_out(b_rd_out), .wb_data_out(b_wb),
    .fwd_valid_out(b_fv), .fwd_rd_out(b_frd), .fwd_data_out(b_fdat)
  );

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          rw;
    logic [4:0]  rd;
    logic [63:0] dat;
  } ent_t;

  ent_t q_a[$];
  ent_t q_b[$];
  bit   a_fresh = 0, b_fresh = 0;
  bit   a_started = 0, b_started = 0;

  // Load value from a byte view of memory: size in bytes, natural alignment, optional sign.
  function automatic logic [63:0] exp_load(input int w, input logic [2:0] f3, input int off,
                                           input logic [63:0] mem);
    int size;
    bit sgn;
    int base;
    logic [63:0] v;
    logic [63:0] ones;
    size = 0;
    sgn  = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = (w == 64); end
      3'd4: size = 1;
      3'd5: size = 2;
      3'd6: size = (w == 64) ? 4 : 0;
      3'd3: size = (w == 64) ? 8 : 0;
      default: size = 0;
    endcase
    if (size == 0 || size * 8 == w) return mem;
    base = (off / size) * size;
    v = 64'd0;
    for (int i = 0; i < size; i++) v = v | (64'(mem[8*(base+i) +: 8]) << (8 * i));
    ones = {64{1'b1}};
    if (sgn && v[8*size-1]) v = v | (ones << (8 * size));
    if (w == 32) v = {32'd0, v[31:0]};
    return v;
  endfunction

  // Model: an in-order queue of depth 2; pop when consumer ready, push when not full before the edge.
  always @(posedge clk) begin
    ent_t e;
    bit pop, push;
    if (a_rst) begin
      q_a.delete(); a_fresh = 1; a_started = 1;
    end else if (a_flush) begin
      q_a.delete(); a_fresh = 0;
    end else begin
      pop  = (q_a.size() > 0) && a_rdy_in;
      push = a_vin && (q_a.size() < 2);
      e.rw  = a_rw;
      e.rd  = a_rd;
      e.dat = a_m2r ? exp_load(32, a_f3, int'(a_off), {32'd0, a_mem}) : {32'd0, a_alu};
      if (pop) void'(q_a.pop_front());
      if (push) begin q_a.push_back(e); a_fresh = 0; end
    end
    if (b_rst) begin
      q_b.delete(); b_fresh = 1; b_started = 1;
    end else if (b_flush) begin
      q_b.delete(); b_fresh = 0;
    end else begin
      pop  = (q_b.size() > 0) && b_rdy_in;
      push = b_vin && (q_b.size() < 2);
      e.rw  = b_rw;
      e.rd  = b_rd;
      e.dat = b_m2r ? exp_load(64, b_f3, int'(b_off), b_mem) : b_alu;
      if (pop) void'(q_b.pop_front());
      if (push) begin q_b.push_back(e); b_fresh = 0; end
    end
  end

  task automatic cmp(input string t, input int sz, input ent_t head, input bit fresh,
                     input logic vo, input logic ro, input logic rwo, input logic [4:0] rdo,
                     input logic [63:0] dato, input logic fv, input logic [4:0] frd,
                     input logic [63:0] fdat);
    bit exp_rw;
    exp_rw = (sz > 0) && head.rw && (head.rd != 5'd0);
    chk({t, "_valid_out"}, vo, 64'(sz > 0));
    chk({t, "_ready_out"}, ro, 64'(sz < 2));
    chk({t, "_reg_write_out"}, rwo, 64'(exp_rw));
    chk({t, "_fwd_valid_out"}, fv, 64'(exp_rw));
    if (sz > 0) begin
      chk({t, "_rd_out"}, rdo, 64'(head.rd));
      chk({t, "_wb_data_out"}, dato, head.dat);
      chk({t, "_fwd_rd_out"}, frd, 64'(head.rd));
      chk({t, "_fwd_data_out"}, fdat, head.dat);
    end else if (fresh) begin
      chk({t, "_rd_out_rst"}, rdo, 64'd0);
      chk({t, "_wb_data_out_rst"}, dato, 64'd0);
      chk({t, "_fwd_rd_out_rst"}, frd, 64'd0);
      chk({t, "_fwd_data_out_rst"}, fdat, 64'd0);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    ent_t ha, hb;
    ha.rw = 0; ha.rd = '0; ha.dat = '0;
    hb = ha;
    if (q_a.size() > 0) ha = q_a[0];
    if (q_b.size() > 0) hb = q_b[0];
    if (a_started)
      cmp("a", q_a.size(), ha, a_fresh, a_vout, a_rdy_out, a_rw_out, a_rd_out, {32'd0, a_wb},
          a_fv, a_frd, {32'd0, a_fdat});
    if (b_started)
      cmp("b", q_b.size(), hb, b_fresh, b_vout, b_rdy_out, b_rw_out, b_rd_out, b_wb,
          b_fv, b_frd, b_fdat);
  end

  // ---------------- stimulus ----------------
  task automatic offer_a(input bit v, input bit m2r, input bit rw, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] off, input logic [31:0] mem,
                         input logic [31:0] alu);
    a_vin = v; a_m2r = m2r; a_rw = rw; a_rd = rd; a_f3 = f3; a_off = off; a_mem = mem; a_alu = alu;
  endtask

  task automatic offer_b(input bit v, input bit m2r, input bit rw, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [2:0] off, input logic [63:0] mem,
                         input logic [63:0] alu);
    b_vin = v; b_m2r = m2r; b_rw = rw; b_rd = rd; b_f3 = f3; b_off = off; b_mem = mem; b_alu = alu;
  endtask

  initial begin
    logic [31:0] lb_exp [4];
    lb_exp[0] = 32'h00000001; lb_exp[1] = 32'h0000007F;
    lb_exp[2] = 32'hFFFFFFFF; lb_exp[3] = 32'hFFFFFF80;

    a_rst = 1; a_flush = 0; a_rdy_in = 1;
    b_rst = 1; b_flush = 0; b_rdy_in = 1;
    offer_a(0, 0, 0, 0, 0, 0, 0, 0);
    offer_b(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_valid_out", a_vout, 0);
    chk("rst_ready_out", a_rdy_out, 1);
    chk("rst_wb_data_out", a_wb, 0);
    chk("rst_fwd_valid_out", a_fv, 0);
    a_rst = 0;

    // Stream three ALU results, unstalled
    offer_a(1, 0, 1, 5'd1, 0, 0, 0, 32'h11); @(negedge clk);
    chk("stream_wb0", a_wb, 32'h11); chk("stream_rdy0", a_rdy_out, 1);
    offer_a(1, 0, 1, 5'd2, 0, 0, 0, 32'h22); @(negedge clk);
    chk("stream_wb1", a_wb, 32'h22); chk("stream_rdy1", a_rdy_out, 1);
    offer_a(1, 0, 1, 5'd3, 0, 0, 0, 32'h33); @(negedge clk);
    chk("stream_wb2", a_wb, 32'h33); chk("stream_rd2", a_rd_out, 3);

    // Load extraction
    for (int i = 0; i < 4; i++) begin
      offer_a(1, 1, 1, 5'd4, 3'b000, 2'(i), 32'h80FF7F01, 32'hDEAD); @(negedge clk);
      chk("lb_lane", a_wb, 64'(lb_exp[i]));
    end
    offer_a(1, 1, 1, 5'd4, 3'b101, 2'd2, 32'h80FF7F01, 0); @(negedge clk);
    chk("lhu_off2", a_wb, 32'h000080FF);
    offer_a(1, 1, 1, 5'd4, 3'b001, 2'd3, 32'h80FF7F01, 0); @(negedge clk);
    chk("lh_off3", a_wb, 32'hFFFF80FF);
    offer_a(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("drain_valid", a_vout, 0);

    // Stall: A to main, B to skid, C refused
    a_rdy_in = 0;
    offer_a(1, 0, 1, 5'd5, 0, 0, 0, 32'hA); @(negedge clk);
    chk("stall_a_wb", a_wb, 32'hA); chk("stall_a_rdy", a_rdy_out, 1);
    offer_a(1, 0, 1, 5'd6, 0, 0, 0, 32'hB); @(negedge clk);
    chk("stall_b_wb", a_wb, 32'hA); chk("stall_b_rdy", a_rdy_out, 0);
    offer_a(1, 0, 1, 5'd7, 0, 0, 0, 32'hC); @(negedge clk);
    chk("stall_c_wb", a_wb, 32'hA); chk("stall_c_rdy", a_rdy_out, 0);
    a_rdy_in = 1;
    offer_a(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("release_b_wb", a_wb, 32'hB); chk("release_rdy", a_rdy_out, 1);
    offer_a(1, 0, 1, 5'd7, 0, 0, 0, 32'hC); @(negedge clk);
    chk("release_c_wb", a_wb, 32'hC); chk("release_c_rd", a_rd_out, 7);
    offer_a(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("release_empty", a_vout, 0);

    // Write to x0 is valid but not a register write
    offer_a(1, 0, 1, 5'd0, 0, 0, 0, 32'h55); @(negedge clk);
    chk("x0_valid", a_vout, 1); chk("x0_reg_write", a_rw_out, 0); chk("x0_fwd_valid", a_fv, 0);
    offer_a(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);

    // Flush with both entries full and a new offer
    a_rdy_in = 0;
    offer_a(1, 0, 1, 5'd8, 0, 0, 0, 32'hD); @(negedge clk);
    offer_a(1, 0, 1, 5'd9, 0, 0, 0, 32'hE); @(negedge clk);
    chk("flush_pre_rdy", a_rdy_out, 0);
    a_flush = 1;
    offer_a(1, 0, 1, 5'd10, 0, 0, 0, 32'hF); @(negedge clk);
    chk("flush_valid", a_vout, 0); chk("flush_rdy", a_rdy_out, 1);
    a_flush = 0; a_rdy_in = 1;
    offer_a(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("flush_dropped", a_vout, 0);

    // 64-bit word loads and reset mid-stall
    b_rst = 0;
    offer_b(1, 1, 1, 5'd3, 3'b010, 3'd0, 64'h00000000_80000000, 0); @(negedge clk);
    chk("lw64", b_wb, 64'hFFFFFFFF_80000000);
    offer_b(1, 1, 1, 5'd3, 3'b110, 3'd0, 64'h00000000_80000000, 0); @(negedge clk);
    chk("lwu64", b_wb, 64'h00000000_80000000);
    offer_b(1, 1, 1, 5'd3, 3'b010, 3'd4, 64'h80000000_00000001, 0); @(negedge clk);
    chk("lw64_off4", b_wb, 64'hFFFFFFFF_80000000);
    offer_b(1, 1, 1, 5'd3, 3'b011, 3'd5, 64'h11223344_55667788, 0); @(negedge clk);
    chk("ld64", b_wb, 64'h11223344_55667788);
    b_rdy_in = 0;
    offer_b(1, 0, 1, 5'd4, 0, 0, 0, 64'h1); @(negedge clk);
    offer_b(1, 0, 1, 5'd5, 0, 0, 0, 64'h2); @(negedge clk);
    chk("b_stall_rdy", b_rdy_out, 0);
    b_rst = 1;
    offer_b(0, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("b_rst_valid", b_vout, 0); chk("b_rst_rdy", b_rdy_out, 1);
    chk("b_rst_wb", b_wb, 0); chk("b_rst_rd", b_rd_out, 0);
    chk("b_rst_rw", b_rw_out, 0); chk("b_rst_fwd", b_fv, 0);
    b_rst = 0;

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      a_rst    = ($urandom_range(0, 199) == 0);
      a_flush  = ($urandom_range(0, 24) == 0);
      a_rdy_in = ($urandom_range(0, 9) < 6);
      offer_a($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
              5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              $urandom, $urandom);
      b_rst    = ($urandom_range(0, 199) == 0);
      b_flush  = ($urandom_range(0, 24) == 0);
      b_rdy_in = ($urandom_range(0, 9) < 6);
      offer_b($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 1),
              5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
    end

    a_rst = 0; a_flush = 0; a_rdy_in = 1; offer_a(0, 0, 0, 0, 0, 0, 0, 0);
    b_rst = 0; b_flush = 0; b_rdy_in = 1; offer_b(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
